hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 16-bit 5-stage datapath. Drives the IF/ID register's stall (StopPC), flush (FlushIn) and Halt controls, plus the ID/EX bubble and the global freeze. Resolves load-use hazards, taken-branch flushes, data-memory wait states and the halt/resume sequence. Counts stall cycles for performance debug.

## Interface
Parameters:
- REGW, 4, register-address width
- FLUSH_CYCLES, 2, cycles Flush is held after a taken branch (1..15)
- DRAIN_CYCLES, 3, cycles allowed for EX/MEM/WB to retire before Halt asserts (1..15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- id_rs, id_rt  in  REGW  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  the ID instruction actually reads rs / rt
- ex_memread  in  1  the instruction in EX is a load
- ex_rd  in  REGW  destination register of the EX instruction
- branch_taken  in  1  branch/jump resolved taken in EX
- halt_detect  in  1  the ID instruction is HALT
- mem_busy  in  1  data memory not ready this cycle
- resume  in  1  single-cycle pulse that leaves the halted state
- clr_count  in  1  synchronous clear of StallCount
- StopPC  out  1  hold the PC and IF/ID
- Flush  out  1  to IF/ID FlushIn; squash the fetched instruction
- Bubble  out  1  insert a NOP into ID/EX
- Freeze  out  1  hold every pipeline register
- Halt  out  1  to IF/ID Halt
- StallCount  out  16  saturating count of stall cycles

## Operation
- States: RUN, FLUSH, MEM_WAIT, DRAIN, HALTED. A 4-bit down-counter cnt serves FLUSH and DRAIN.
- Outputs are a combinational decode of the state and the current inputs. State, cnt and StallCount are registered.
- Load-use hazard (lu) = ex_memread && ex_rd != 0 && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd)).
- Priority in every state except HALTED: mem_busy is highest.
  - When mem_busy is active: StopPC = 1, Freeze = 1, all other controls 0.
  - State and cnt hold. Non-RUN states resume where they left off once mem_busy drops.
  - From RUN, go to MEM_WAIT. Return to RUN on the first cycle mem_busy = 0.
- RUN, taking the first match:
  1. branch_taken: Flush = 1, Bubble = 1. If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES-2.
  2. lu: StopPC = 1, Bubble = 1 for that cycle. Stay in RUN; the hazard clears once the load advances.
  3. halt_detect: StopPC = 1, Bubble = 1. Go to DRAIN with cnt = DRAIN_CYCLES-1.
  4. Otherwise: all outputs 0.
- FLUSH: Flush = 1, Bubble = 1. When cnt = 0, go to RUN; otherwise decrement cnt. branch_taken, lu and halt_detect are ignored.
- DRAIN: StopPC = 1, Bubble = 1. When cnt = 0, go to HALTED; otherwise decrement cnt. branch_taken is ignored, because the HALT precedes the branch in program order.
- HALTED: Halt = 1, StopPC = 1, Bubble = 1; mem_busy is ignored. When resume = 1, go to RUN; Halt drops the cycle after resume.
- resume is ignored in every state other than HALTED.
- StallCount:
  - Increments each cycle StopPC = 1 and the state is not HALTED.
  - Saturates at 0xFFFF.
  - clr_count has priority over increment: the counter reads 0 on the next cycle.

## Timing
- Reset (rst low, any time, including mid-FLUSH or mid-DRAIN):
  - state = RUN, cnt = 0, StallCount = 0.
  - All outputs 0 while in reset, regardless of inputs.
  - First possible assertion is in the cycle after rst rises.
- Zero-latency decode: a hazard present in cycle N gives StopPC/Flush/Bubble in cycle N.
- Output duration per event:
  - Load-use stall: 1 cycle.
  - Branch flush: exactly FLUSH_CYCLES cycles of Flush.
  - Halt: DRAIN_CYCLES+1 cycles of StopPC (the detect cycle plus DRAIN), then Halt = 1.
- Freeze is never asserted together with Flush or Halt.

## Test plan
- Load-use: ex_memread = 1, ex_rd = 3, id_rs = 3, id_uses_rs = 1 -> StopPC = Bubble = 1 for 1 cycle, StallCount = 1. Repeat with ex_rd = 0 -> no stall.
- Branch: branch_taken pulsed 1 cycle with FLUSH_CYCLES = 2 -> Flush = 1 for exactly 2 cycles. A second branch_taken in the FLUSH cycle -> still 2 cycles total.
- mem_busy held 3 cycles, with branch_taken asserted in the same first cycle -> Freeze = 1 for 3 cycles, Flush = 0. Branch re-presented afterwards -> 2-cycle flush.
- Halt: halt_detect pulse -> StopPC = 1 for 4 cycles, then Halt = 1 held for 10 cycles. resume pulse -> Halt = 0 next cycle. StallCount = 4.
- Reset asserted mid-DRAIN -> all outputs 0 immediately, StallCount = 0. After release with no hazards, outputs stay 0.
- Saturation: preload StallCount near max via a long mem_busy -> it holds at 0xFFFF. clr_count -> 0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/bubble/freeze/halt sequencing with a saturating stall counter
module hazard_ctrl #(
  parameter int REGW         = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            ex_memread,
  input  logic [REGW-1:0] ex_rd,
  input  logic            branch_taken,
  input  logic            halt_detect,
  input  logic            mem_busy,
  input  logic            resume,
  input  logic            clr_count,
  output logic            StopPC,
  output logic            Flush,
  output logic            Bubble,
  output logic            Freeze,
  output logic            Halt,
  output logic [15:0]     StallCount
);
  typedef enum logic [2:0] {RUN, FLUSH, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       lu;
  assign lu = ex_memread && ex_rd != '0 &&
              ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      cnt        <= '0;
      StallCount <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      StallCount <= clr_count ? '0 :
                    (StopPC && state != HALTED && StallCount != 16'hFFFF) ? StallCount + 16'd1 :
                    StallCount;
    end
  end
  // MEM_WAIT with mem_busy low decodes like RUN so nothing presented that cycle is lost
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    StopPC  = 1'b0;
    Flush   = 1'b0;
    Bubble  = 1'b0;
    Freeze  = 1'b0;
    Halt    = 1'b0;
    if (rst) begin
      if (state == HALTED) begin
        Halt   = 1'b1;
        StopPC = 1'b1;
        Bubble = 1'b1;
        if (resume) state_n = RUN;
      end else if (mem_busy) begin
        StopPC = 1'b1;
        Freeze = 1'b1;
        if (state == RUN) state_n = MEM_WAIT;
      end else if (state == FLUSH) begin
        Flush   = 1'b1;
        Bubble  = 1'b1;
        state_n = cnt == '0 ? RUN : FLUSH;
        cnt_n   = cnt == '0 ? cnt : cnt - 4'd1;
      end else if (state == DRAIN) begin
        StopPC  = 1'b1;
        Bubble  = 1'b1;
        state_n = cnt == '0 ? HALTED : DRAIN;
        cnt_n   = cnt == '0 ? cnt : cnt - 4'd1;
      end else begin
        state_n = RUN;
        if (branch_taken) begin
          Flush  = 1'b1;
          Bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_n = FLUSH;
            cnt_n   = 4'(FLUSH_CYCLES - 2);
          end
        end else if (lu) begin
          StopPC = 1'b1;
          Bubble = 1'b1;
        end else if (halt_detect) begin
          StopPC  = 1'b1;
          Bubble  = 1'b1;
          state_n = DRAIN;
          cnt_n   = 4'(DRAIN_CYCLES - 1);
        end
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl; outputs packed as {StopPC,Flush,Bubble,Freeze,Halt}
module tb_hazard_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic [3:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
  logic        id_uses_rs = 0, id_uses_rt = 0, ex_memread = 0, branch_taken = 0;
  logic        halt_detect = 0, mem_busy = 0, resume = 0, clr_count = 0;
  logic        StopPC, Flush, Bubble, Freeze, Halt;
  logic [15:0] StallCount;
  int          tests = 0, fails = 0;
  localparam logic [4:0] NONE = 5'b00000, STALL = 5'b10100, FLSH = 5'b01100,
                         FRZ = 5'b10010, HLT = 5'b10101;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .halt_detect(halt_detect), .mem_busy(mem_busy),
    .resume(resume), .clr_count(clr_count), .StopPC(StopPC), .Flush(Flush),
    .Bubble(Bubble), .Freeze(Freeze), .Halt(Halt), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [4:0] exp);
    #1;
    check(tag, {27'd0, StopPC, Flush, Bubble, Freeze, Halt}, {27'd0, exp});
  endtask

  task automatic idle;
    id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rs = 0; id_uses_rt = 0; ex_memread = 0;
    branch_taken = 0; halt_detect = 0; mem_busy = 0; resume = 0; clr_count = 0;
  endtask

  initial begin
    branch_taken = 1; halt_detect = 1; mem_busy = 1;
    tick;
    outs("reset_outs", NONE);
    check("reset_count", StallCount, 0);
    idle;
    rst = 1'b1;
    tick;
    outs("post_reset", NONE);
    // load-use on rs
    ex_memread = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
    outs("lu_rs", STALL);
    tick; idle;
    outs("lu_done", NONE);
    check("lu_count", StallCount, 1);
    ex_memread = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    outs("lu_r0", NONE);
    tick; idle;
    check("lu_r0_count", StallCount, 1);
    ex_memread = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1;
    outs("lu_rt", STALL);
    id_uses_rt = 0;
    outs("lu_rt_unused", NONE);
    ex_memread = 0; id_uses_rt = 1;
    outs("lu_not_load", NONE);
    tick; idle;
    check("lu_rt_count", StallCount, 1);
    // branch flush, second branch ignored
    branch_taken = 1;
    outs("br_c0", FLSH);
    tick;
    outs("br_c1", FLSH);
    tick; idle;
    outs("br_end", NONE);
    // mem_busy beats branch
    mem_busy = 1; branch_taken = 1;
    outs("mb_c0", FRZ);
    tick; branch_taken = 0;
    outs("mb_c1", FRZ);
    tick;
    outs("mb_c2", FRZ);
    tick; idle;
    outs("mb_end", NONE);
    tick;
    branch_taken = 1;
    outs("br2_c0", FLSH);
    tick; idle;
    mem_busy = 1;
    outs("br2_busy", FRZ);
    tick; mem_busy = 0;
    outs("br2_c1", FLSH);
    tick;
    outs("br2_end", NONE);
    // halt sequence
    clr_count = 1;
    tick; idle;
    check("clr_count", StallCount, 0);
    halt_detect = 1;
    outs("halt_det", STALL);
    tick; halt_detect = 0; branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      outs($sformatf("drain_%0d", i), STALL);
      tick;
    end
    idle;
    for (int i = 0; i < 10; i++) begin
      mem_busy = (i == 4);
      outs($sformatf("halted_%0d", i), HLT);
      tick;
    end
    idle;
    check("halt_count", StallCount, 4);
    resume = 1;
    outs("resume_cyc", HLT);
    tick; idle;
    outs("resumed", NONE);
    check("resume_count", StallCount, 4);
    // reset in the middle of DRAIN
    halt_detect = 1;
    tick; idle;
    tick;
    rst = 1'b0;
    outs("rst_mid_outs", NONE);
    check("rst_mid_count", StallCount, 0);
    tick;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      outs($sformatf("after_rst_%0d", i), NONE);
    end
    check("after_rst_count", StallCount, 0);
    // saturation via long mem_busy
    mem_busy = 1;
    repeat (65540) tick;
    outs("sat_outs", FRZ);
    check("sat_count", StallCount, 16'hFFFF);
    clr_count = 1;
    tick; clr_count = 0;
    check("sat_clr", StallCount, 0);
    tick; idle;
    check("sat_restart", StallCount, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
